// File: rtl/fetch_if.sv
// Fetch stage interface: pipeline control into fetch, fetch-to-decode/imem outputs.
// The master side is the fetch stage; the slave side is the pipeline around it.
interface fetch_if;
  logic        clk_en;
  logic        stall;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic [31:0] pc_out;
  logic        bubble_out;
  logic [7:0]  exc_out;
  logic [31:0] fetch_count;

  modport master (
    input  clk_en, stall, halt, redirect, redirect_pc,
    output mem_addr, pc_out, bubble_out, exc_out, fetch_count
  );

  modport slave (
    output clk_en, stall, halt, redirect, redirect_pc,
    input  mem_addr, pc_out, bubble_out, exc_out, fetch_count
  );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage. Holds the fetch PC (driven straight out as the imem address)
// and registers pc/bubble/exc so they line up with the word memory returns one cycle later.
// Optional feature: define FETCH_MISALIGN_EXC_EN to raise exception 8'h83 on a misaligned
// fetch and park in a fault state until redirected; otherwise redirect targets are
// word-aligned by clearing bits [1:0].
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e      r_state,       w_state_nxt;
  logic [31:0] r_fetch_pc,    w_fetch_pc_nxt;
  logic [31:0] r_pc_out,      w_pc_out_nxt;
  logic        r_bubble,      w_bubble_nxt;
  logic [7:0]  r_exc,         w_exc_nxt;
  logic [31:0] r_count,       w_count_nxt;
  logic        r_pend_valid,  w_pend_valid_nxt;
  logic [31:0] r_pend_pc,     w_pend_pc_nxt;
  logic [31:0] w_target;
  logic        w_misaligned;

  // Redirect target: a live redirect wins over one parked during halt.
  always_comb begin
    w_target = bus.redirect ? bus.redirect_pc : r_pend_pc;
`ifdef FETCH_MISALIGN_EXC_EN
    w_misaligned = (r_fetch_pc[1:0] != 2'b00);
`else
    w_target[1:0] = 2'b00;
    w_misaligned  = 1'b0;
`endif
  end

  // Next-state: priority halt > redirect > pending redirect > stall > issue.
  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_pc_out_nxt     = r_pc_out;
    w_bubble_nxt     = r_bubble;
    w_exc_nxt        = r_exc;
    w_count_nxt      = r_count;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    if (bus.clk_en) begin
      if (bus.halt) begin
        // Park a redirect seen during halt; the latest one wins.
        if (bus.redirect) begin
          w_pend_valid_nxt = 1'b1;
          w_pend_pc_nxt    = bus.redirect_pc;
        end
      end else if (bus.redirect || r_pend_valid) begin
        w_fetch_pc_nxt   = w_target;
        w_bubble_nxt     = 1'b1;
        w_exc_nxt        = 8'h00;
        w_state_nxt      = StRun;
        w_pend_valid_nxt = 1'b0;
      end else if (!bus.stall) begin
        unique case (r_state)
          StRun: begin
            w_pc_out_nxt = r_fetch_pc;
            w_bubble_nxt = 1'b0;
            if (w_misaligned) begin
              // Report the faulting address once, then hold PC until redirected.
              w_exc_nxt   = 8'h83;
              w_state_nxt = StFault;
            end else begin
              w_exc_nxt      = 8'h00;
              w_fetch_pc_nxt = r_fetch_pc + 32'd4;
              w_count_nxt    = r_count + 32'd1;
            end
          end
          StFault: begin
            w_bubble_nxt = 1'b1;
            w_exc_nxt    = 8'h00;
          end
          default: begin
            w_state_nxt = StRun;
          end
        endcase
      end
    end
  end

  // State register with asynchronous reset; reset also drops any parked redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StRun;
      r_fetch_pc   <= RESET_PC;
      r_pc_out     <= 32'h0;
      r_bubble     <= 1'b1;
      r_exc        <= 8'h00;
      r_count      <= 32'h0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_pc_out     <= w_pc_out_nxt;
      r_bubble     <= w_bubble_nxt;
      r_exc        <= w_exc_nxt;
      r_count      <= w_count_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
    end
  end

  assign bus.mem_addr    = r_fetch_pc;
  assign bus.pc_out      = r_pc_out;
  assign bus.bubble_out  = r_bubble;
  assign bus.exc_out     = r_exc;
  assign bus.fetch_count = r_count;

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the Dioptase pipeline; the producer end of the fetch→decode interface. Holds the fetch PC, drives the synchronous instruction-memory address, and presents `pc_out`/`bubble_out`/`exc_out` aligned with the word that memory returns on `mem_out_0`, so decode can register all of them on the same edge. Applies redirects (taken branches, exception entry, `rfe`/`rfi`) from later stages and obeys the pipeline stall, halt and clock-enable.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_en`  in  1  global clock enable; when low no state changes.
- `stall`  in  1  pipeline stall from downstream.
- `halt`  in  1  core halted.
- `redirect`  in  1  squash in-flight fetch and load `redirect_pc`.
- `redirect_pc`  in  32  new fetch address.
- `mem_addr`  out  32  instruction-memory read address, equal to `fetch_pc`; memory captures it on each rising edge.
- `pc_out`  out  32  address of the word currently on `mem_out_0`.
- `bubble_out`  out  1  word on `mem_out_0` is not a valid instruction.
- `exc_out`  out  8  fetch exception code, 0 = none.
- `fetch_count`  out  32  count of valid (non-bubble) fetches issued; wraps.

## Operation
- State:
  - `fetch_pc`, 32-bit.
  - `pend_valid`/`pend_pc`, for a redirect held during halt.
  - FSM with states RUN and FAULT.
- Priority at each edge with `clk_en`=1, highest first:
  1. `rst`
  2. `halt`
  3. `redirect`
  4. pending redirect
  5. `stall`
  6. normal issue
- halt:
  - `fetch_pc`, `pc_out`, `bubble_out`, `fetch_count` and the FSM hold.
  - If `redirect`=1: `pend_valid`<=1, `pend_pc`<=`redirect_pc`. A later redirect during the same halt overwrites it.
- redirect (live, or pending when `halt`=0):
  - `fetch_pc`<=target; `bubble_out`<=1; `exc_out`<=0; `pc_out` holds; FSM<=RUN; `pend_valid`<=0.
  - A live redirect overrides a pending one and also overrides `stall`.
- stall without redirect: all outputs and state hold.
- Normal issue in RUN:
  - `pc_out`<=`fetch_pc`, `bubble_out`<=0, `exc_out`<=0.
  - `fetch_pc`<=`fetch_pc`+4, wrapping modulo 2^32 (32'hFFFF_FFFC→0).
  - `fetch_count`+=1, wrapping.
- Normal issue in FAULT: `bubble_out`<=1, `exc_out`<=0, `fetch_pc` holds. Leaves FAULT only on redirect or reset.
- Reset values:
  - `fetch_pc`=`RESET_PC`, `pc_out`=0, `bubble_out`=1, `exc_out`=0, `fetch_count`=0.
  - `pend_valid`=0, FSM=RUN.
  - Reset mid-halt discards a pending redirect.

## Timing
- `mem_addr` is a register output; there is no combinational path from any input.
- Memory read latency is 1 cycle. A word is addressed at edge E. After E, `mem_out_0`, `pc_out` and `bubble_out` all describe that word. Decode samples them at E+1.
- First valid instruction: the first enabled edge after reset release issues `RESET_PC`. `bubble_out` falls after that edge.
- Redirect penalty:
  - The edge that accepts the redirect produces exactly one bubble.
  - The target is issued on the next non-stalled enabled edge.
- Steady state: throughput of 1 word per cycle.
- `clk_en`=0: nothing changes, including FSM and pending state.

## Configuration
- `FETCH_MISALIGN_EXC_EN` defined:
  - At a normal issue in RUN with `fetch_pc[1:0]`≠0: `pc_out`<=`fetch_pc`, `bubble_out`<=0, `exc_out`<=8'h83, FSM<=FAULT, `fetch_pc` holds, `fetch_count` unchanged.
  - `exc_out` returns to 0 on the next issue edge.
- Not defined:
  - Redirect targets are loaded with bits [1:0] forced to 0.
  - The FAULT state is unreachable, and `exc_out` is constant 0.

## Test plan
- Reset release with `RESET_PC`=32'h400 and no stall → `pc_out` sequence 400, 404, 408 on successive edges; `bubble_out`=1 only before the first edge; `fetch_count`=3 after 3 edges.
- `redirect` to 32'h1000 while `fetch_pc`=32'h40C → one cycle with `bubble_out`=1, then `pc_out`=1000, then 1004; the word at 40C is never issued valid.
- `stall` for 3 cycles at `fetch_pc`=32'h20, with a `redirect` to 32'h80 in the 2nd stall cycle → holds through cycle 1, then the redirect is taken; the next valid `pc_out`=80.
- `halt`=1 with `redirect` to 32'h2000 pulsed, then `halt`=0 → nothing moves during halt; on release, one bubble, then `pc_out`=2000.
- `fetch_pc` at 32'hFFFF_FFFC → next issue is address 0.
- With `FETCH_MISALIGN_EXC_EN`, `redirect` to 32'h1002 → `pc_out`=1002 with `exc_out`=83 for one cycle, then bubbles until `redirect` to 32'h1004 resumes normal fetch. Without the macro, the same stimulus fetches 1000, 1004.
